// File: rtl/btn_debounce_port.sv
// btn_debounce_port: N-channel button/switch input conditioner.
// Each bit has a synchroniser, a tick-gated debounce counter and sticky
// rising/falling edge flags that the CPU side clears bit by bit.
// Optional feature macro: BTN_DEBOUNCE_IRQ_EN adds irq_mask/irq (masked
// flag interrupt). Without it the ports and their logic are absent.
module btn_debounce_port #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             tick,
    input  logic [WIDTH-1:0] clr_re,
    input  logic [WIDTH-1:0] clr_fe,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] re_flag,
    output logic [WIDTH-1:0] fe_flag,
    output logic             any_flag
`ifdef BTN_DEBOUNCE_IRQ_EN
    ,
    input  logic [WIDTH-1:0] irq_mask,
    output logic             irq
`endif
);

    localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [CNT_W-1:0] r_cnt  [WIDTH];

    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_flip;
    logic [WIDTH-1:0] w_set_re;
    logic [WIDTH-1:0] w_set_fe;
    logic [CNT_W-1:0] w_cnt_nxt [WIDTH];

    assign w_s = r_sync[SYNC_STAGES-1];

    // Synchroniser chain: the only consumer of the raw asynchronous din.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < int'(SYNC_STAGES); k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= din;
            for (int k = 1; k < int'(SYNC_STAGES); k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    // Per-bit stability counter: restart on agreement, advance on ticks, flip on the last tick.
    always_comb begin
        w_flip = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (w_s[i] == dout[i]) begin
                w_cnt_nxt[i] = '0;
            end else if (tick) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_cnt_nxt[i] = '0;
                    w_flip[i]    = 1'b1;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
        w_set_re = w_flip & w_s;
        w_set_fe = w_flip & ~w_s;
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    // Debounced level and sticky edge flags; a same-cycle set beats a clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dout    <= '0;
            re_flag <= '0;
            fe_flag <= '0;
        end else begin
            dout    <= dout ^ w_flip;
            re_flag <= (re_flag & ~clr_re) | w_set_re;
            fe_flag <= (fe_flag & ~clr_fe) | w_set_fe;
        end
    end

    // Summary flag, one clock behind the flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            any_flag <= 1'b0;
        end else begin
            any_flag <= |(re_flag | fe_flag);
        end
    end

`ifdef BTN_DEBOUNCE_IRQ_EN
    // Masked interrupt request, one clock behind the flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            irq <= 1'b0;
        end else begin
            irq <= |((re_flag | fe_flag) & irq_mask);
        end
    end
`endif

endmodule

// File: tb/tb_btn_debounce_port.sv
// Bench for btn_debounce_port: directed scenarios plus random stimulus,
// every cycle compared against a behavioural model of the channel rules.
module tb_btn_debounce_port;

    localparam int unsigned W    = 4;
    localparam int unsigned SYNC = 2;
    localparam int unsigned DEB  = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] din;
    logic         tick;
    logic [W-1:0] clr_re;
    logic [W-1:0] clr_fe;
    logic [W-1:0] dout;
    logic [W-1:0] re_flag;
    logic [W-1:0] fe_flag;
    logic         any_flag;
    logic [W-1:0] irq_mask;
`ifdef BTN_DEBOUNCE_IRQ_EN
    logic         irq;
`endif

    btn_debounce_port #(
        .WIDTH      (W),
        .SYNC_STAGES(SYNC),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .din     (din),
        .tick    (tick),
        .clr_re  (clr_re),
        .clr_fe  (clr_fe),
        .dout    (dout),
        .re_flag (re_flag),
        .fe_flag (fe_flag),
        .any_flag(any_flag)
`ifdef BTN_DEBOUNCE_IRQ_EN
        ,
        .irq_mask(irq_mask),
        .irq     (irq)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [W-1:0] m_pipe [$];
    int           m_run  [W];
    logic [W-1:0] m_dout, m_re, m_fe;
    logic         m_any, m_irq;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pipe.delete();
        repeat (SYNC) m_pipe.push_back('0);
        for (int i = 0; i < int'(W); i++) m_run[i] = 0;
        m_dout = '0; m_re = '0; m_fe = '0; m_any = 1'b0; m_irq = 1'b0;
    endtask

    // One rising edge: the level seen after SYNC clocks must disagree for DEB
    // consecutive ticks (no agreeing clock in between) before dout takes it.
    task automatic model_edge();
        logic [W-1:0] s, rise, fall;
        if (!reset) begin
            model_reset();
            return;
        end
        s    = m_pipe.pop_front();
        m_pipe.push_back(din);
        rise = '0;
        fall = '0;
        m_any = |(m_re | m_fe);
        m_irq = |((m_re | m_fe) & irq_mask);
        for (int i = 0; i < int'(W); i++) begin
            if (s[i] == m_dout[i]) begin
                m_run[i] = 0;
            end else if (tick) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == int'(DEB)) begin
                    m_run[i] = 0;
                    if (s[i]) rise[i] = 1'b1;
                    else      fall[i] = 1'b1;
                end
            end
        end
        m_dout = (m_dout | rise) & ~fall;
        m_re   = (m_re & ~clr_re) | rise;
        m_fe   = (m_fe & ~clr_fe) | fall;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_eq("dout",     32'(dout),     32'(m_dout));
        check_eq("re_flag",  32'(re_flag),  32'(m_re));
        check_eq("fe_flag",  32'(fe_flag),  32'(m_fe));
        check_eq("any_flag", 32'(any_flag), 32'(m_any));
`ifdef BTN_DEBOUNCE_IRQ_EN
        check_eq("irq",      32'(irq),      32'(m_irq));
`endif
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clear_flags();
        clr_re = '1; clr_fe = '1;
        step();
        clr_re = '0; clr_fe = '0;
    endtask

    initial begin
        logic [W-1:0] held;
        bit           seen;
        model_reset();
        reset = 1'b0; din = 4'hF; tick = 1'b1;
        clr_re = '0; clr_fe = '0; irq_mask = 4'b0100;

        // Reset held with all inputs high
        steps(3);
        check_eq("rst_dout", 32'(dout), 32'd0);
        check_eq("rst_re",   32'(re_flag), 32'd0);
        check_eq("rst_any",  32'(any_flag), 32'd0);

        // Release: all four channels rise together
        reset = 1'b1;
        steps(8);
        check_eq("rel_dout", 32'(dout), 32'hF);
        check_eq("rel_re",   32'(re_flag), 32'hF);
        clear_flags();
        din = 4'h0;
        steps(8);
        clear_flags();
        steps(2);

        // Glitch rejection: 3-clk pulse ignored, 4-clk pulse passes
        din[0] = 1'b1; steps(3); din[0] = 1'b0; steps(8);
        check_eq("glitch3_re", 32'(re_flag[0]), 32'd0);
        din[0] = 1'b1; steps(4); din[0] = 1'b0; steps(10);
        check_eq("pulse4_re", 32'(re_flag[0]), 32'd1);
        check_eq("pulse4_fe", 32'(fe_flag[0]), 32'd1);
        clear_flags();

        // Tick gating: one tick in ten, then tick held low
        din[2] = 1'b1;
        for (int c = 0; c < 60; c++) begin
            tick = (c % 10 == 0);
            step();
        end
        tick = 1'b0;
        held = m_dout;
        din[2] = 1'b0;
        steps(20);
        check_eq("tick0_hold", 32'(dout), 32'(held));
        tick = 1'b1;
        steps(8);
        clear_flags();

        // Set/clear race on re_flag[1]
        din[1] = 1'b1; clr_re[1] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            seen = m_re[1];
        end
        check_eq("race_seen", 32'(seen), 32'd1);
        check_eq("race_set",  32'(re_flag[1]), 32'd1);
        step();
        check_eq("race_clr",  32'(re_flag[1]), 32'd0);
        clr_re[1] = 1'b0;
        steps(3);
        clear_flags();

        // Reset mid-debounce on bit 3
        din = 4'b1000;
        steps(4);
        reset = 1'b0; step(); reset = 1'b1;
        check_eq("midrst_dout", 32'(dout[3]), 32'd0);
        steps(10);
        clear_flags();

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < int'(W); b++)
                if ($urandom_range(0, 5) == 0) din[b] = ~din[b];
            tick     = ($urandom_range(0, 3) != 0);
            clr_re   = W'($urandom & $urandom);
            clr_fe   = W'($urandom & $urandom);
            irq_mask = W'($urandom);
            reset    = ($urandom_range(0, 199) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
